// File: rtl/layer0_input_pack.sv
// Quantizes a stream of signed feature samples to 2-bit codes and packs one
// well-formed frame per output word; malformed frames are dropped and counted.
module layer0_input_pack #(
    parameter int unsigned            IN_W     = 8,
    parameter int unsigned            NUM_FEAT = 16,
    parameter int unsigned            BITS     = 2,
    parameter logic signed [IN_W-1:0] T0       = IN_W'(-32),
    parameter logic signed [IN_W-1:0] T1       = IN_W'(0),
    parameter logic signed [IN_W-1:0] T2       = IN_W'(32)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic signed [IN_W-1:0]      s_data,
    input  logic                        s_last,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [NUM_FEAT*BITS-1:0]    m_data,
    output logic [7:0]                  err_cnt
);

    localparam int unsigned IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam int unsigned DW    = NUM_FEAT * BITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DISCARD = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [DW-1:0]    r_buf;
    logic [DW-1:0]    w_buf_wr;
    logic [DW-1:0]    r_m_data;
    logic             r_m_valid;
    logic             r_s_ready;
    logic [7:0]       r_err_cnt;
    logic [BITS-1:0]  w_code;
    logic             w_beat;
    logic             w_out_free;
    logic             w_at_last;
    logic             w_buf_we;
    logic             w_load_new;
    logic             w_load_buf;
    logic             w_err_inc;

    assign w_beat     = s_valid & r_s_ready;
    assign w_out_free = ~r_m_valid | m_ready;
    assign w_at_last  = (r_idx == LAST_IDX);

    // Threshold quantizer (signed compares)
    always_comb begin
        w_code = BITS'(3);
        if (s_data < T0)      w_code = BITS'(0);
        else if (s_data < T1) w_code = BITS'(1);
        else if (s_data < T2) w_code = BITS'(2);
    end

    // Buffer image with the current beat's code inserted at the current index
    always_comb begin
        w_buf_wr = r_buf;
        for (int unsigned i = 0; i < NUM_FEAT; i++) begin
            if (r_idx == IDX_W'(i)) w_buf_wr[i*BITS +: BITS] = w_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_COLLECT;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_COLLECT: begin
                if (w_beat && w_at_last) begin
                    if (!s_last)          w_state_nxt = ST_DISCARD;
                    else if (!w_out_free) w_state_nxt = ST_FULL;
                end
            end
            ST_DISCARD: if (w_beat && s_last) w_state_nxt = ST_COLLECT;
            ST_FULL:    if (w_out_free)       w_state_nxt = ST_COLLECT;
            default:    w_state_nxt = ST_COLLECT;
        endcase
    end

    always_comb begin
        w_buf_we   = 1'b0;
        w_load_new = 1'b0;
        w_load_buf = 1'b0;
        w_err_inc  = 1'b0;
        w_idx_nxt  = r_idx;
        case (r_state)
            ST_COLLECT: begin
                if (w_beat) begin
                    w_buf_we = 1'b1;
                    if (s_last) begin
                        w_idx_nxt = '0;
                        if (!w_at_last)      w_err_inc  = 1'b1;
                        else if (w_out_free) w_load_new = 1'b1;
                    end else if (w_at_last) begin
                        w_err_inc = 1'b1;
                        w_idx_nxt = '0;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            ST_DISCARD: if (w_beat && s_last) w_idx_nxt = '0;
            ST_FULL:    if (w_out_free)       w_load_buf = 1'b1;
            default:    w_idx_nxt = '0;
        endcase
    end

    // Datapath and registered outputs; s_ready follows the next state only
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= '0;
            r_buf     <= '0;
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_s_ready <= (w_state_nxt != ST_FULL);
            r_idx     <= w_idx_nxt;
            if (w_buf_we) r_buf <= w_buf_wr;
            if (w_load_new) begin
                r_m_data  <= w_buf_wr;
                r_m_valid <= 1'b1;
            end else if (w_load_buf) begin
                r_m_data  <= r_buf;
                r_m_valid <= 1'b1;
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
            if (w_err_inc && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign s_ready = r_s_ready;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_layer0_input_pack.sv
// Bench for layer0_input_pack: frame-level reference model (queues of whole
// frames and a drop counter) checked against the DUT every cycle.
module tb_layer0_input_pack;

    localparam int NF = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic signed [7:0] s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [31:0]       m_data;
    logic [7:0]        err_cnt;

    always #5 clk = ~clk;

    layer0_input_pack dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .err_cnt (err_cnt)
    );

    logic [31:0] exp_q[$];
    int          beats[$];
    int          err_m;
    bit          disc_m;
    int          mr_mode;
    int          frame_data[64];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int quant(input int x);
        if (x < -32) return 0;
        if (x < 0)   return 1;
        if (x < 32)  return 2;
        return 3;
    endfunction

    function automatic logic [31:0] pack_frame();
        logic [31:0] res = '0;
        foreach (beats[i]) res = res | (32'(quant(beats[i])) << (2 * i));
        return res;
    endfunction

    function automatic void model_beat(input int v, input bit last);
        if (disc_m) begin
            if (last) disc_m = 1'b0;
            return;
        end
        beats.push_back(v);
        if (last) begin
            if (beats.size() == NF) exp_q.push_back(pack_frame());
            else if (err_m < 255) err_m++;
            beats.delete();
        end else if (beats.size() == NF) begin
            if (err_m < 255) err_m++;
            disc_m = 1'b1;
            beats.delete();
        end
    endfunction

    // One clock: update the model with this cycle's handshakes, then check.
    task automatic tick();
        bit r;
        case (mr_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        r = rst;
        if (r) begin
            exp_q.delete();
            beats.delete();
            err_m  = 0;
            disc_m = 1'b0;
        end else begin
            if (m_valid && m_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (s_valid && s_ready) model_beat(int'(s_data), s_last);
        end
        @(posedge clk);
        #1;
        if (r) begin
            check_eq("rst_s_ready", 64'(s_ready), 64'(0));
            check_eq("rst_m_valid", 64'(m_valid), 64'(0));
            check_eq("rst_m_data",  64'(m_data),  64'(0));
            check_eq("rst_err_cnt", 64'(err_cnt), 64'(0));
        end else begin
            check_eq("s_ready", 64'(s_ready), 64'(exp_q.size() < 2));
            check_eq("m_valid", 64'(m_valid), 64'(exp_q.size() > 0));
            check_eq("err_cnt", 64'(err_cnt), 64'(err_m));
            if (exp_q.size() > 0) check_eq("m_data", 64'(m_data), 64'(exp_q[0]));
        end
    endtask

    task automatic send_beat(input int v, input bit last);
        bit acc;
        int waited = 0;
        s_valid = 1'b1;
        s_data  = 8'(v);
        s_last  = last;
        forever begin
            acc = s_ready;
            tick();
            if (acc) break;
            waited++;
            if (waited > 200) begin
                check_eq("beat_timeout", 64'(1), 64'(0));
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int len, input bit gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) tick();
            send_beat(frame_data[i], i == len - 1);
        end
    endtask

    function automatic int rnd_sample();
        int pick[9] = '{-33, -32, -31, -1, 0, 1, 31, 32, 33};
        if ($urandom_range(0, 2) == 0) return pick[$urandom_range(0, 8)];
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 64; i++) frame_data[i] = rnd_sample();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int len;
        int pick;
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
        mr_mode = 1;
        do_reset();

        // Directed frame with threshold-edge samples
        fill_random();
        frame_data[0] = -40; frame_data[1] = -32; frame_data[2] = -1;
        frame_data[3] = 0;   frame_data[4] = 31;  frame_data[5] = 32;
        send_frame(NF, 1'b0);
        check_eq("first_m_valid", 64'(m_valid), 64'(1));
        check_eq("first_codes",   64'(m_data[11:0]), 64'(12'hE94));
        idle(3);

        // Frame A held, frame B stalls in FULL, single-cycle drain
        mr_mode = 0;
        fill_random(); send_frame(NF, 1'b0);
        fill_random(); send_frame(NF, 1'b0);
        idle(3);
        check_eq("full_s_ready", 64'(s_ready), 64'(0));
        mr_mode = 1; tick(); mr_mode = 0;
        check_eq("after_drain_s_ready", 64'(s_ready), 64'(1));
        idle(2);
        mr_mode = 1; idle(2);

        // Short frame then good frame
        fill_random(); send_frame(6, 1'b0);
        check_eq("short_err", 64'(err_cnt), 64'(1));
        fill_random(); send_frame(NF, 1'b1);
        idle(2);

        // Long frame then good frame
        do_reset();
        fill_random(); send_frame(20, 1'b0);
        check_eq("long_err", 64'(err_cnt), 64'(1));
        check_eq("long_no_valid", 64'(m_valid), 64'(0));
        fill_random(); send_frame(NF, 1'b1);
        idle(2);

        // Random traffic with backpressure and malformed frames
        do_reset();
        mr_mode = 2;
        for (int f = 0; f < 150; f++) begin
            pick = int'($urandom_range(0, 9));
            if (pick == 0)      len = int'($urandom_range(1, NF - 1));
            else if (pick == 1) len = int'($urandom_range(NF + 1, NF + 8));
            else                len = NF;
            fill_random();
            send_frame(len, 1'b1);
        end
        mr_mode = 1; idle(4);

        // Error counter saturation
        do_reset();
        for (int f = 0; f < 300; f++) begin
            fill_random(); send_frame(2, 1'b0);
        end
        check_eq("err_saturated", 64'(err_cnt), 64'(255));
        fill_random(); send_frame(NF, 1'b0);
        idle(2);

        // Reset while a frame is held and another sits in FULL
        do_reset();
        fill_random(); send_frame(3, 1'b0);
        mr_mode = 0;
        fill_random(); send_frame(NF, 1'b0);
        fill_random(); send_frame(NF, 1'b0);
        idle(1);
        check_eq("pre_rst_m_valid", 64'(m_valid), 64'(1));
        check_eq("pre_rst_err",     64'(err_cnt), 64'(1));
        rst = 1'b1; tick(); rst = 1'b0;
        mr_mode = 1; tick();
        fill_random(); send_frame(NF, 1'b0);
        check_eq("post_rst_m_valid", 64'(m_valid), 64'(1));
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
